// File: rtl/pwm_carrier_controller.sv
// Carrier-synchronous PWM controller: run/stop sequencing, prescaled carrier stepping,
// valley-aligned shadow reload of duty/dead-time, and complementary gate drive with dead time.
module pwm_carrier_controller #(
    parameter int WIDTH_TRIANG = 7,
    parameter int PRESC_W      = 8,
    parameter int DT_W         = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en_req,
    output logic                    en_ack,
    input  logic [PRESC_W-1:0]      presc,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [WIDTH_TRIANG-1:0] cfg_duty,
    input  logic [DT_W-1:0]         cfg_dt,
    input  logic [WIDTH_TRIANG-1:0] carrier,
    output logic                    carrier_step,
    output logic                    pwm_hi,
    output logic                    pwm_lo,
    output logic                    valley
);

    typedef enum logic [1:0] {IDLE, ARM, RUN, DRAIN} state_t;

    localparam logic [WIDTH_TRIANG-1:0] DUTY_FULL = '1;
    localparam logic [DT_W-1:0]         DT_ONE    = DT_W'(1);
    localparam logic [PRESC_W-1:0]      PRESC_ONE = PRESC_W'(1);

    state_t                  state;
    state_t                  state_nxt;
    logic [PRESC_W-1:0]      presc_cnt;
    logic [WIDTH_TRIANG-1:0] duty_act;
    logic [WIDTH_TRIANG-1:0] duty_sh;
    logic [DT_W-1:0]         dt_act;
    logic [DT_W-1:0]         dt_sh;
    logic [DT_W-1:0]         dt_cnt;
    logic                    pending;
    logic                    raw;
    logic                    raw_q;
    logic                    raw_edge;
    logic                    at_zero;
    logic                    valley_evt;
    logic                    handshake;
    logic                    blocked;
    logic                    hi_nxt;
    logic                    lo_nxt;

    // >= rather than == keeps the step rate bounded if presc is lowered mid-count
    always_comb begin
        carrier_step = (state != IDLE) && (presc_cnt >= presc);
        at_zero      = (carrier == '0);
        valley_evt   = carrier_step && at_zero && ((state == ARM) || (state == RUN));
        cfg_ready    = !pending;
        handshake    = cfg_valid && !pending;
        en_ack       = (state == RUN) || (state == DRAIN);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en_req) state_nxt = ARM;
            ARM:     if (!en_req) state_nxt = IDLE;
                     else if (valley_evt) state_nxt = RUN;
            RUN:     if (!en_req) state_nxt = DRAIN;
            DRAIN:   if (en_req) state_nxt = RUN;
                     else if (carrier_step && at_zero) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            presc_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE || carrier_step) begin
                presc_cnt <= '0;
            end else begin
                presc_cnt <= presc_cnt + PRESC_ONE;
            end
        end
    end

    // While stopped a new setting goes straight to the active registers; otherwise it waits for a valley
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            duty_act <= '0;
            dt_act   <= '0;
            duty_sh  <= '0;
            dt_sh    <= '0;
            pending  <= 1'b0;
            valley   <= 1'b0;
        end else begin
            valley <= valley_evt;
            if (handshake) begin
                if (state == IDLE) begin
                    duty_act <= cfg_duty;
                    dt_act   <= cfg_dt;
                end else begin
                    duty_sh <= cfg_duty;
                    dt_sh   <= cfg_dt;
                    pending <= 1'b1;
                end
            end else if (valley_evt && pending) begin
                duty_act <= duty_sh;
                dt_act   <= dt_sh;
                pending  <= 1'b0;
            end
        end
    end

    // Full-scale duty saturates so the output never drops at the carrier peak
    always_comb begin
        raw      = (duty_act == DUTY_FULL) ? 1'b1 : (carrier < duty_act);
        raw_edge = raw ^ raw_q;
        blocked  = raw_edge ? (dt_act != '0) : (dt_cnt > DT_ONE);
        hi_nxt   = !blocked && raw && (state_nxt == RUN);
        lo_nxt   = !blocked && !raw && ((state_nxt == RUN) || (state_nxt == DRAIN));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            raw_q  <= 1'b0;
            dt_cnt <= '0;
            pwm_hi <= 1'b0;
            pwm_lo <= 1'b0;
        end else begin
            raw_q  <= raw;
            pwm_hi <= hi_nxt;
            pwm_lo <= lo_nxt;
            if (raw_edge) begin
                dt_cnt <= dt_act;
            end else if (dt_cnt != '0) begin
                dt_cnt <= dt_cnt - DT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_pwm_carrier_controller.sv
// Self-checking bench for pwm_carrier_controller: a triangle carrier generator as environment,
// a cycle-level behavioural reference model, duty/dead-time table rows and hand-written corner sequences.
module tb_pwm_carrier_controller;

    localparam int WT       = 7;
    localparam int PW       = 8;
    localparam int DW       = 4;
    localparam int CAR_MAX  = (1 << WT) - 1;
    localparam int CAR_PER  = 2 * CAR_MAX;
    localparam int M_IDLE   = 0;
    localparam int M_ARM    = 1;
    localparam int M_RUN    = 2;
    localparam int M_DRAIN  = 3;
    localparam logic [5:0] RESET_VEC = 6'b001000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en_req = 1'b0;
    logic          cfg_valid = 1'b0;
    logic [PW-1:0] presc = '0;
    logic [WT-1:0] cfg_duty = '0;
    logic [DW-1:0] cfg_dt = '0;
    logic [WT-1:0] carrier;
    logic          en_ack, cfg_ready, carrier_step, pwm_hi, pwm_lo, valley;

    int n_compared = 0;
    int n_failed   = 0;

    pwm_carrier_controller #(.WIDTH_TRIANG(WT), .PRESC_W(PW), .DT_W(DW)) dut (
        .clk(clk), .rst(rst), .en_req(en_req), .en_ack(en_ack), .presc(presc),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_duty(cfg_duty), .cfg_dt(cfg_dt),
        .carrier(carrier), .carrier_step(carrier_step), .pwm_hi(pwm_hi), .pwm_lo(pwm_lo),
        .valley(valley)
    );

    always #5 clk = ~clk;

    function automatic int tri_value(input int n);
        int p;
        p = n % CAR_PER;
        return (p <= CAR_MAX) ? p : CAR_PER - p;
    endfunction

    // Environment: triangle carrier generator advanced by the DUT's step enable
    int gen_steps;
    always @(posedge clk or negedge rst) begin
        if (!rst) gen_steps <= 0;
        else if (carrier_step) gen_steps <= gen_steps + 1;
    end
    assign carrier = WT'(tri_value(gen_steps));

    // Reference model state
    int m_mode, m_run_cyc, m_steps, m_duty, m_dt, m_sh_duty, m_sh_dt;
    bit m_pending, m_valley, m_hi, m_lo;
    bit raw_hist[$];

    function automatic bit m_step_now();
        return (m_mode != M_IDLE) && ((m_run_cyc % (int'(presc) + 1)) == int'(presc));
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_run_cyc = 0; m_steps = 0;
        m_duty = 0; m_dt = 0; m_sh_duty = 0; m_sh_dt = 0;
        m_pending = 0; m_valley = 0; m_hi = 0; m_lo = 0;
        raw_hist.delete();
    endtask

    task automatic model_advance();
        bit step, vevt, hs, raw, drive, r;
        int c, nmode, idx;
        if (!rst) begin
            model_reset();
            return;
        end
        step  = m_step_now();
        c     = tri_value(m_steps);
        vevt  = step && (c == 0) && (m_mode == M_ARM || m_mode == M_RUN);
        hs    = cfg_valid && !m_pending;
        raw   = (m_duty == CAR_MAX) ? 1'b1 : (c < m_duty);
        nmode = m_mode;
        case (m_mode)
            M_IDLE:  if (en_req) nmode = M_ARM;
            M_ARM:   if (!en_req) nmode = M_IDLE; else if (vevt) nmode = M_RUN;
            M_RUN:   if (!en_req) nmode = M_DRAIN;
            default: if (en_req) nmode = M_RUN; else if (step && c == 0) nmode = M_IDLE;
        endcase
        // a gate may drive only if raw has held its value for the last dt cycles
        raw_hist.push_back(raw);
        if (raw_hist.size() > 40) void'(raw_hist.pop_front());
        drive = 1'b1;
        for (int k = 0; k <= m_dt; k++) begin
            idx = raw_hist.size() - 1 - k;
            r = (idx >= 0) ? raw_hist[idx] : 1'b0;
            if (r != raw) drive = 1'b0;
        end
        m_hi     = (nmode == M_RUN) && drive && raw;
        m_lo     = (nmode == M_RUN || nmode == M_DRAIN) && drive && !raw;
        m_valley = vevt;
        if (hs) begin
            if (m_mode == M_IDLE) begin
                m_duty = int'(cfg_duty); m_dt = int'(cfg_dt);
            end else begin
                m_sh_duty = int'(cfg_duty); m_sh_dt = int'(cfg_dt); m_pending = 1;
            end
        end else if (vevt && m_pending) begin
            m_duty = m_sh_duty; m_dt = m_sh_dt; m_pending = 0;
        end
        m_run_cyc = (m_mode == M_IDLE) ? 0 : m_run_cyc + 1;
        if (step) m_steps++;
        m_mode = nmode;
    endtask

    task automatic compare(input string name, input int got, input int want);
        n_compared++;
        if (got != want) begin
            n_failed++;
            $display("[TB] FAIL %s @%0t: got %0d, want %0d", name, $time, got, want);
        end
    endtask

    task automatic checkOutput(input string name);
        logic [5:0] act, exp;
        act = {carrier_step, en_ack, cfg_ready, valley, pwm_hi, pwm_lo};
        exp = {m_step_now(), (m_mode == M_RUN || m_mode == M_DRAIN), !m_pending, m_valley, m_hi, m_lo};
        n_compared++;
        if (act !== exp) begin
            n_failed++;
            $display("[TB] FAIL %s @%0t: got step/ack/ready/valley/hi/lo=%b, want %b", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_advance();
        @(negedge clk);
        checkOutput("cycle");
    endtask

    task automatic applyStimulus(input logic en, input logic valid, input int duty, input int dt);
        en_req    = en;
        cfg_valid = valid;
        cfg_duty  = WT'(duty);
        cfg_dt    = DW'(dt);
    endtask

    // Reset is dropped between clock edges to exercise the asynchronous path
    task automatic apply_reset();
        logic [5:0] act;
        #2 rst = 1'b0;
        #1;
        act = {carrier_step, en_ack, cfg_ready, valley, pwm_hi, pwm_lo};
        n_compared++;
        if (act !== RESET_VEC) begin
            n_failed++;
            $display("[TB] FAIL async_reset @%0t: got %b, want %b", $time, act, RESET_VEC);
        end
        model_reset();
        applyStimulus(1'b0, 1'b0, 0, 0);
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic cfg_load(input int duty, input int dt);
        applyStimulus(en_req, 1'b1, duty, dt);
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic wait_ack(input logic want, input int budget, input string name);
        for (int i = 0; i < budget && en_ack != want; i++) tick();
        compare(name, int'(en_ack), int'(want));
    endtask

    task automatic count_gates(input int cycles, output int hi, output int lo);
        hi = 0; lo = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            hi += int'(pwm_hi);
            lo += int'(pwm_lo);
        end
    endtask

    typedef struct {
        int duty;
        int dt;
        int exp_hi;
        int exp_lo;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int hi, lo, steps, ack_low, sel, duty;
        logic en;
        bit seen;

        // per-period gate counts with presc=0: raw-high run is 2*duty-1 cycles, each side loses dt
        vecs[0] = '{duty: 0,   dt: 0, exp_hi: 0,   exp_lo: 254};
        vecs[1] = '{duty: 127, dt: 0, exp_hi: 254, exp_lo: 0};
        vecs[2] = '{duty: 64,  dt: 0, exp_hi: 127, exp_lo: 127};
        vecs[3] = '{duty: 64,  dt: 5, exp_hi: 122, exp_lo: 122};
        vecs[4] = '{duty: 32,  dt: 3, exp_hi: 60,  exp_lo: 188};
        vecs[5] = '{duty: 1,   dt: 0, exp_hi: 1,   exp_lo: 253};
        vecs[6] = '{duty: 100, dt: 2, exp_hi: 197, exp_lo: 53};

        apply_reset();
        tick();
        compare("idle_ack", int'(en_ack), 0);

        foreach (vecs[v]) begin
            apply_reset();
            presc = '0;
            cfg_load(vecs[v].duty, vecs[v].dt);
            en_req = 1'b1;
            wait_ack(1'b1, 700, "row_ack_rise");
            repeat (CAR_PER) tick();
            count_gates(CAR_PER, hi, lo);
            compare($sformatf("row%0d_hi_count", v), hi, vecs[v].exp_hi);
            compare($sformatf("row%0d_lo_count", v), lo, vecs[v].exp_lo);
            en_req = 1'b0;
        end

        // presc=3: one step every 4 clocks
        apply_reset();
        presc = PW'(3);
        cfg_load(64, 0);
        en_req = 1'b1;
        wait_ack(1'b1, 2000, "presc3_ack_rise");
        steps = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            steps += int'(carrier_step);
        end
        compare("presc3_step_count", steps, 10);

        // mid-period reload with a refused second offer
        apply_reset();
        presc = '0;
        cfg_load(64, 2);
        en_req = 1'b1;
        wait_ack(1'b1, 700, "reload_ack_rise");
        repeat (60) tick();
        cfg_load(32, 2);
        compare("ready_low_after_hs", int'(cfg_ready), 0);
        cfg_load(100, 2);
        compare("ready_low_while_pending", int'(cfg_ready), 0);
        for (int i = 0; i < 600 && !valley; i++) tick();
        compare("valley_seen", int'(valley), 1);
        compare("ready_high_at_valley", int'(cfg_ready), 1);
        repeat (CAR_PER) tick();
        count_gates(CAR_PER, hi, lo);
        compare("reload_hi_count", hi, 61);

        // stop request: high side off next cycle, ack drops at the valley
        for (int i = 0; i < 300 && !pwm_hi; i++) tick();
        compare("hi_active_before_stop", int'(pwm_hi), 1);
        en_req = 1'b0;
        tick();
        compare("hi_off_in_drain", int'(pwm_hi), 0);
        compare("ack_held_in_drain", int'(en_ack), 1);
        wait_ack(1'b0, 600, "ack_fall_at_valley");

        // restart, then stop and resume before the valley
        en_req = 1'b1;
        wait_ack(1'b1, 600, "restart_ack_rise");
        repeat (30) tick();
        en_req = 1'b0;
        repeat (20) tick();
        en_req = 1'b1;
        ack_low = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            ack_low += int'(!en_ack);
        end
        compare("resume_ack_low_cycles", ack_low, 0);

        // abort from ARM
        en_req = 1'b0;
        wait_ack(1'b0, 600, "abort_prep_ack_fall");
        en_req = 1'b1;
        repeat (10) tick();
        en_req = 1'b0;
        repeat (5) tick();
        compare("arm_abort_ack", int'(en_ack), 0);

        // reset inside a dead-time window
        apply_reset();
        cfg_load(64, 8);
        en_req = 1'b1;
        wait_ack(1'b1, 700, "dt_ack_rise");
        seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            tick();
            seen = !pwm_hi && !pwm_lo;
        end
        compare("dead_window_found", int'(seen), 1);
        tick();
        apply_reset();
        repeat (20) tick();
        compare("idle_after_reset_ack", int'(en_ack), 0);
        compare("idle_after_reset_ready", int'(cfg_ready), 1);

        // randomized run/stop and reconfiguration at a fixed dead time
        apply_reset();
        presc = PW'(1);
        cfg_load(50, 4);
        for (int i = 0; i < 3000; i++) begin
            en = en_req;
            if ($urandom_range(0, 299) == 0) en = !en;
            sel  = $urandom_range(0, 3);
            duty = (sel == 0) ? 0 : (sel == 1) ? CAR_MAX : int'($urandom_range(0, CAR_MAX));
            applyStimulus(en, ($urandom_range(0, 19) == 0), duty, 4);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule
